// File: rtl/alu_pkg.sv
// Shared definitions for the ALU controller: opcode encodings and FSM state encoding.
// Used by alu_ctrl, alu_regfile and the testbench.
package alu_pkg;

    localparam logic [3:0] OP_MOV  = 4'b0000;
    localparam logic [3:0] OP_INC  = 4'b0001;
    localparam logic [3:0] OP_SUBB = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_ADDC = 4'b0101;
    localparam logic [3:0] OP_MOVB = 4'b0110;
    localparam logic [3:0] OP_DEC  = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_NOT  = 4'b1011;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_WB   = 2'd2;

endpackage

// File: rtl/alu_regfile.sv
// Register file: 2**AWIDTH x DSIZE, one synchronous write port, three combinational
// read ports; cleared by the asynchronous reset.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int DSIZE  = 16,
    parameter int AWIDTH = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DSIZE-1:0]  wdata,
    input  logic [AWIDTH-1:0] raddr_a,
    output logic [DSIZE-1:0]  rdata_a,
    input  logic [AWIDTH-1:0] raddr_b,
    output logic [DSIZE-1:0]  rdata_b,
    input  logic [AWIDTH-1:0] raddr_c,
    output logic [DSIZE-1:0]  rdata_c
);

    localparam int NREGS = 1 << AWIDTH;

    logic [DSIZE-1:0] mem [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Reads return pre-edge contents, so a same-cycle write is not forwarded.
    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];
    assign rdata_c = mem[raddr_c];

endmodule

// File: rtl/alu_ctrl.sv
// Three-state (IDLE/EXEC/WB) controller that sequences operands to an external ALU and
// writes results back. Optional macro ALU_CTRL_ZFLAG_EN adds a zero-flag output flag_z.
module alu_ctrl
    import alu_pkg::*;
#(
    parameter int OPSIZE = 4,
    parameter int DSIZE  = 16,
    parameter int AWIDTH = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPSIZE-1:0] in_op,
    input  logic [AWIDTH-1:0] in_rd,
    input  logic [AWIDTH-1:0] in_ra,
    input  logic [AWIDTH-1:0] in_rb,
    input  logic              ext_wr,
    input  logic [AWIDTH-1:0] ext_addr,
    input  logic [DSIZE-1:0]  ext_wdata,
    output logic [DSIZE-1:0]  ext_rdata,
    output logic [OPSIZE-1:0] alu_op,
    output logic [DSIZE-1:0]  alu_a,
    output logic [DSIZE-1:0]  alu_b,
    input  logic [DSIZE-1:0]  alu_f,
    input  logic              alu_n,
    input  logic              alu_c,
    input  logic              alu_v,
    output logic              done,
    output logic              flag_n,
    output logic              flag_c,
    output logic              flag_v
`ifdef ALU_CTRL_ZFLAG_EN
    ,
    output logic              flag_z
`endif
);

    state_t state;
    state_t state_next;

    logic              accept;
    logic [AWIDTH-1:0] rd_q;
    logic [DSIZE-1:0]  res_q;
    logic              n_q;
    logic              c_q;
    logic              v_q;

    logic              rf_we;
    logic [AWIDTH-1:0] rf_waddr;
    logic [DSIZE-1:0]  rf_wdata;
    logic [DSIZE-1:0]  rd_a;
    logic [DSIZE-1:0]  rd_b;

    assign in_ready = (state == ST_IDLE);
    assign accept   = in_valid && in_ready;
    assign done     = (state == ST_WB);

    // Writeback and host writes never collide: host writes only land in IDLE.
    assign rf_we    = (state == ST_WB) || ((state == ST_IDLE) && ext_wr);
    assign rf_waddr = (state == ST_WB) ? rd_q  : ext_addr;
    assign rf_wdata = (state == ST_WB) ? res_q : ext_wdata;

    alu_regfile #(
        .DSIZE  (DSIZE),
        .AWIDTH (AWIDTH)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (in_ra),
        .rdata_a (rd_a),
        .raddr_b (in_rb),
        .rdata_b (rd_b),
        .raddr_c (ext_addr),
        .rdata_c (ext_rdata)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = ST_EXEC;
            ST_EXEC: state_next = ST_WB;
            ST_WB:   state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ALU-facing registers load only on accept, so they hold their last values outside EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op <= '0;
            alu_a  <= '0;
            alu_b  <= '0;
            rd_q   <= '0;
        end else if (accept) begin
            alu_op <= in_op;
            alu_a  <= rd_a;
            alu_b  <= rd_b;
            rd_q   <= in_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
            n_q   <= 1'b0;
            c_q   <= 1'b0;
            v_q   <= 1'b0;
        end else if (state == ST_EXEC) begin
            res_q <= alu_f;
            n_q   <= alu_n;
            c_q   <= alu_c;
            v_q   <= alu_v;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_n <= 1'b0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
        end else if (state == ST_WB) begin
            flag_n <= n_q;
            flag_c <= c_q;
            flag_v <= v_q;
        end
    end

`ifdef ALU_CTRL_ZFLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z <= 1'b0;
        end else if (state == ST_WB) begin
            flag_z <= (res_q == '0);
        end
    end
`endif

endmodule
